// File: rtl/l2_bank_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// l2_mem_pkg: shared types and constants for the L2 bank controllers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package l2_mem_pkg;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    DRAIN    = 2'd1,
    CLEAR    = 2'd2,
    WAIT_REL = 2'd3
  } bank_state_e;

  localparam logic [31:0] L2_BASE_ADDR = 32'h1C00_0000;
  localparam int unsigned RD_LAT_MIN   = 1;
  localparam int unsigned RD_LAT_MAX   = 2;

endpackage

`default_nettype wire

// File: rtl/l2_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// l2_tcdm_if / l2_sram_if: TCDM slave port and single-port SRAM macro port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface l2_tcdm_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = DATA_W / 8
);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned WORD_W = DATA_W + TAG_W;

  logic              req;
  logic [31:0]       add;
  logic              wen;
  logic [BE_W-1:0]   be;
  logic [WORD_W-1:0] wdata;
  logic              gnt;
  logic              r_valid;
  logic [WORD_W-1:0] r_rdata;
  logic              r_opc;

  modport slave  (input  req, add, wen, be, wdata, output gnt, r_valid, r_rdata, r_opc);
  modport master (output req, add, wen, be, wdata, input  gnt, r_valid, r_rdata, r_opc);
endinterface

interface l2_sram_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = DATA_W / 8,
  parameter int unsigned DEPTH  = 32768
);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned WORD_W = DATA_W + TAG_W;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              csn;
  logic              wen;
  logic [BE_W-1:0]   ben;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;

  modport master (output csn, wen, ben, addr, wdata, input  rdata);
  modport slave  (input  csn, wen, ben, addr, wdata, output rdata);
endinterface

`default_nettype wire

// File: rtl/l2_bank_ctrl_resp_pipe.sv
// ---------------------------------------------------------------------------
// l2_bank_resp_pipe: RD_LAT-deep response tracker with optional data register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module l2_bank_resp_pipe #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WORD_W = 36
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_valid,
  input  logic              push_read,
  input  logic              push_err,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              r_valid,
  output logic              r_opc,
  output logic [WORD_W-1:0] r_rdata,
  output logic              empty
);

  logic [RD_LAT-1:0] vld_q, rd_q, err_q;
  logic [RD_LAT-1:0] vld_d, rd_d, err_d;
  logic [WORD_W-1:0] data_w;
  logic              hit_w;

  if (RD_LAT == 1) begin : g_shift1
    assign vld_d = push_valid;
    assign rd_d  = push_read;
    assign err_d = push_err;
  end else begin : g_shiftn
    assign vld_d = {vld_q[RD_LAT-2:0], push_valid};
    assign rd_d  = {rd_q[RD_LAT-2:0],  push_read};
    assign err_d = {err_q[RD_LAT-2:0], push_err};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      rd_q  <= '0;
      err_q <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
      err_q <= err_d;
    end
  end

  // SRAM data is only valid in the cycle after the access, so a 2-cycle
  // response captures it there and holds it for one more cycle.
  if (RD_LAT == 1) begin : g_rd_direct
    assign data_w = mem_rdata;
  end else begin : g_rd_reg
    logic [WORD_W-1:0] data_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       data_q <= '0;
      else if (vld_q[0]) data_q <= mem_rdata;
    end
    assign data_w = data_q;
  end

  assign hit_w   = vld_q[RD_LAT-1] & rd_q[RD_LAT-1] & ~err_q[RD_LAT-1];
  assign r_valid = vld_q[RD_LAT-1];
  assign r_opc   = vld_q[RD_LAT-1] & err_q[RD_LAT-1];
  assign r_rdata = hit_w ? data_w : '0;
  assign empty   = ~|vld_q;

endmodule

`default_nettype wire

// File: rtl/l2_bank_ctrl.sv
// ---------------------------------------------------------------------------
// l2_bank_ctrl: per-bank TCDM-to-SRAM controller with range check and scrub
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module l2_bank_ctrl
  import l2_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = DATA_W / 8,
  parameter int unsigned DEPTH     = 32768,
  parameter int unsigned NB_BANKS  = 4,
  parameter logic [31:0] BASE_ADDR = L2_BASE_ADDR,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       init_ni,
  input  logic       test_mode_i,
  l2_tcdm_if.slave   tcdm,
  l2_sram_if.master  mem,
  output logic       init_done_o
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned WORD_W = DATA_W + TAG_W;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned BANK_W = $clog2(NB_BANKS);
  localparam int unsigned LAT    = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                                   (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;
  localparam logic [32:0] SPAN   = 33'(64'(DEPTH) * 64'(NB_BANKS) * 64'd4);

  bank_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [31:0]       off_w;
  logic              in_range_w;
  logic [ADDR_W-1:0] word_w;
  logic              gnt_w, pipe_empty_w;
  logic              csn_w, wen_w;
  logic [BE_W-1:0]   ben_w;
  logic [ADDR_W-1:0] addr_w;
  logic [WORD_W-1:0] wdata_w;

  // Offset wraps modulo 2^32, so addresses below the base land out of range.
  assign off_w      = tcdm.add - BASE_ADDR;
  assign in_range_w = {1'b0, off_w} < SPAN;
  assign word_w     = off_w[ADDR_W+2+BANK_W-1 : 2+BANK_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == CLEAR) ? cnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_w   = 1'b0;
    csn_w   = 1'b1;
    wen_w   = 1'b1;
    ben_w   = '1;
    addr_w  = word_w;
    wdata_w = tcdm.wdata;
    unique case (state_q)
      READY: begin
        if (!init_ni && !test_mode_i) begin
          state_d = DRAIN;
        end else begin
          gnt_w = tcdm.req;
          if (tcdm.req && in_range_w) begin
            csn_w = 1'b0;
            wen_w = tcdm.wen;
            ben_w = tcdm.wen ? '0 : ~tcdm.be;
          end
        end
      end
      DRAIN: begin
        if (pipe_empty_w) state_d = CLEAR;
      end
      CLEAR: begin
        csn_w   = 1'b0;
        wen_w   = 1'b0;
        ben_w   = '0;
        addr_w  = cnt_q;
        wdata_w = '0;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (init_ni) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  l2_bank_resp_pipe #(
    .RD_LAT (LAT),
    .WORD_W (WORD_W)
  ) u_resp_pipe (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_valid (gnt_w),
    .push_read  (tcdm.wen),
    .push_err   (~in_range_w),
    .mem_rdata  (mem.rdata),
    .r_valid    (tcdm.r_valid),
    .r_opc      (tcdm.r_opc),
    .r_rdata    (tcdm.r_rdata),
    .empty      (pipe_empty_w)
  );

  assign tcdm.gnt    = gnt_w;
  assign mem.csn     = csn_w;
  assign mem.wen     = wen_w;
  assign mem.ben     = ben_w;
  assign mem.addr    = addr_w;
  assign mem.wdata   = wdata_w;
  assign init_done_o = (state_q == READY);

endmodule

`default_nettype wire

// File: doc/l2_bank_ctrl.md
Name: l2_bank_ctrl

Overview:
- Parametrised per-bank controller between one TCDM slave port (36-bit data+tag flavour, generalised) and one single-port SRAM macro.
- Generalises the fixed 1-cycle bank glue: configurable data/tag width, depth, interleaving, base address and read latency.
- Adds out-of-range error responses and a hardware zero-fill (scrub) sequencer.
- Instantiated once per interleaved bank and once per private bank in the L2 memory subsystem.

Parameters:
- DATA_W, 32, data bits per word; must be a multiple of 8.
- TAG_W, DATA_W/8, tag bits per word (one per byte); 0 disables tags.
- DEPTH, 32768, words in this bank; power of two.
- NB_BANKS, 4, interleaving factor; 1 for a private bank.
- BASE_ADDR, 32'h1C00_0000, byte base address of the region this bank belongs to.
- RD_LAT, 1, cycles from grant to r_valid; legal values 1 and 2 (2 = SRAM output register).

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- init_ni, in, 1, active-low request to zero-fill the bank; level sensitive, sampled in READY.
- test_mode_i, in, 1, when 1 init_ni is ignored.
- req_i, in, 1, TCDM request.
- add_i, in, 32, byte address.
- wen_i, in, 1, 1 = read, 0 = write.
- be_i, in, DATA_W/8, byte enables, active high.
- wdata_i, in, DATA_W+TAG_W, data in [DATA_W-1:0], tags above.
- gnt_o, out, 1, grant.
- r_valid_o, out, 1, response valid, for reads and writes.
- r_rdata_o, out, DATA_W+TAG_W, read data; 0 on error and on writes.
- r_opc_o, out, 1, 1 = error (out of range).
- init_done_o, out, 1, high while in READY.
- mem_csn_o, out, 1, SRAM chip select, active low.
- mem_wen_o, out, 1, SRAM write enable, active low (0 = write).
- mem_ben_o, out, DATA_W/8, SRAM byte enables, active low.
- mem_addr_o, out, log2(DEPTH), SRAM word address.
- mem_wdata_o, out, DATA_W+TAG_W, SRAM write data.
- mem_rdata_i, in, DATA_W+TAG_W, SRAM read data, valid 1 cycle after access.

Behaviour:
- Reset values: r_valid_o=0, r_opc_o=0, r_rdata_o=0, mem_csn_o=1, pipeline empty. The FSM resets to READY, so init_done_o=1.
- Address decode: off = add_i - BASE_ADDR, 32-bit modulo. Word index = off[log2(DEPTH)+2+log2(NB_BANKS)-1 : 2+log2(NB_BANKS)].
- In range: off < DEPTH*NB_BANKS*4 (unsigned). Out of range: no SRAM access.
- READY: gnt_o = req_i, combinational. On grant with in-range address: mem_csn_o=0, mem_wen_o=wen_i, mem_ben_o=~be_i (all 0 for reads), address and wdata forwarded.
- Responses:
  - Exactly RD_LAT cycles after each grant, r_valid_o=1 for one cycle. Back-to-back grants produce back-to-back responses.
  - r_opc_o=1 and r_rdata_o=0 for out-of-range accesses.
  - Reads return mem_rdata_i, registered once more when RD_LAT=2.
  - Writes return r_rdata_o=0.
  - When TAG_W=0, tag fields are absent.
- FSM READY -> DRAIN: in READY with init_ni=0 and test_mode_i=0. gnt_o=0 from this cycle.
- DRAIN: gnt_o=0; outstanding responses complete normally. Go to CLEAR when the response pipeline is empty.
- CLEAR:
  - Counter cnt runs 0..DEPTH-1, one write per cycle: mem_csn_o=0, mem_wen_o=0, mem_ben_o=0, mem_wdata_o=0, mem_addr_o=cnt.
  - gnt_o=0; no r_valid for scrub writes.
  - At cnt=DEPTH-1, go to WAIT_REL.
- WAIT_REL: gnt_o=0; go to READY when init_ni=1. Prevents re-triggering while init_ni is held low.
- init_done_o is 0 in DRAIN, CLEAR and WAIT_REL.
- Reset asserted mid-CLEAR: FSM returns to READY immediately; partial clear is not resumed.
- req_i while not READY: held off (gnt_o=0); the master keeps req_i asserted per TCDM rules.

Decomposition:
- Package l2_mem_pkg: state enum (READY, DRAIN, CLEAR, WAIT_REL), address-map base constants, legal RD_LAT range.
- One sub-module, l2_bank_resp_pipe: RD_LAT-deep shift of {valid, is_read, err}, plus optional read-data register; exposes an empty flag for DRAIN.

Test Plan:
- DEPTH=1024, NB_BANKS=4, RD_LAT=1: write 0xDEADBEEF, tag 4'b1010, be=4'hF to BASE+0x10 (word 1) -> next cycle r_valid=1, r_opc=0. Read same address -> r_rdata={4'b1010, 32'hDEADBEEF} 1 cycle after grant.
- Partial write be=4'b0100, data 0x00AA0000 over 0xDEADBEEF -> mem_ben_o=4'b1011; readback 0xDEAABEEF.
- Read at BASE+DEPTH*16 -> gnt=1, mem_csn_o stays 1, r_valid=1 with r_opc=1, r_rdata=0. Read at BASE-4 (wrap) -> same error response.
- RD_LAT=2, four back-to-back reads -> four consecutive r_valid pulses, each 2 cycles after its grant, data in order.
- Pulse init_ni low with two reads in flight -> both responses delivered, then exactly DEPTH scrub writes with gnt_o=0. init_done_o returns to 1 only after init_ni=1. Readback of word 1 = 0.
- Assert rst_ni at cnt=500 of CLEAR -> all outputs at reset values, init_done_o=1. test_mode_i=1 with init_ni=0 -> no scrub.
